res_packer: RTL and testbench
=============================

Name: res_packer

Overview:
- Downstream consumer of the bfm result stream.
- Collects the 8-bit res samples produced each cycle and packs them into 255-bit words, the width the DPI result sink (recv_res) takes.
- Buffers completed words in a small FIFO with a valid/ready output so the DPI-side drain loop can stall without losing data.
- Flags a sticky overflow if the free-running bfm side pushes while the block cannot accept.

Parameters:
- DATA_W, 8, width of one result sample.
- WORD_W, 255, width of one packed output word.
- BYTES_PER_WORD, 32, samples per word (ceil(WORD_W/DATA_W)).
- DEPTH, 4, output word FIFO depth (power of 2, >=2).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous active-low reset.
- res_i  in  DATA_W  result sample from bfm.
- res_valid_i  in  1  res_i valid this cycle.
- res_last_i  in  1  with res_valid_i: this sample ends the packet; flush partial word.
- res_ready_o  out  1  block can accept a sample this cycle.
- word_o  out  WORD_W  packed word at FIFO head.
- word_valid_o  out  1  FIFO non-empty.
- word_ready_i  in  1  consumer accepts word_o.
- word_last_o  out  1  head word closed a packet.
- fill_cnt_o  out  6  samples held in the partial word (0..31).
- overflow_o  out  1  sticky: res_valid_i seen while res_ready_o=0.

Behaviour:
- Reset is sampled on clk_i with reset_i=0. It clears the accumulator, fill_cnt, FIFO pointers/count and overflow_o, and forces state FILL. Outputs in reset: res_ready_o=1, word_valid_o=0, word_last_o=0, fill_cnt_o=0, overflow_o=0, word_o=0. Reset mid-word discards the partial word and all FIFO contents.
- Packing: sample k (0-based in the word) goes to word bits [8k+7:8k]. Sample 31 supplies only bits [254:248]; its bit 7 is dropped. Bits above the last written sample are 0.
- Accept condition: res_valid_i & res_ready_o. Accepting increments fill_cnt.
- A word completes on acceptance of sample 31, or on any accepted sample with res_last_i=1. word_last_o for that word = res_last_i.
- FSM:
  - FILL: res_ready_o=1. On completion, if FIFO has space (count<DEPTH, or a pop occurs the same cycle), push the word, clear the accumulator and stay in FILL; otherwise go to HOLD with the word latched.
  - HOLD: res_ready_o=0. When count<DEPTH or a pop occurs, push the latched word, clear the accumulator and return to FILL. The next cycle accepts samples again.
- Latency: a completing sample accepted in cycle N into an empty FIFO gives word_valid_o=1 in cycle N+1.
- FIFO: pop on word_valid_o & word_ready_i. Push and pop in the same cycle is legal at any count, including full; count is unchanged.
- word_o, word_last_o: registered FIFO head. Stable while word_valid_o=1 and word_ready_i=0.
- overflow_o: set on res_valid_i=1 & res_ready_o=0. The sample is discarded. Cleared only by reset.
- res_last_i without res_valid_i is ignored. A last on an empty accumulator cannot occur, because every accepted sample adds one.
- fill_cnt_o wraps to 0 on every completion.

Optional Feature:
- Macro RES_PACKER_PARITY_EN.
- Defined:
  - Adds output word_par_o (1 bit), the XOR of all WORD_W bits of the head word, stored in the FIFO alongside it.
  - Adds input par_err_inj_i; when it is 1 at the push cycle, the stored parity is inverted (for checker testing).
- Undefined: neither port exists; no parity storage.

Test Plan:
- Stream 32 samples 0x00..0x1F with word_ready_i=1 -> one word.
  - bits [7:0]=0x00, [15:8]=0x01, ..., [254:248]=0x1F.
  - word_last_o=0.
  - word_valid_o high exactly one cycle after the 32nd accept.
- 31 samples of 0x00, then 0xFF -> word_o[254:248]=0x7F, all other bits 0 (bit 7 of sample 31 dropped).
- Samples 0xAA, 0xBB, 0xCC with res_last_i on 0xCC -> word_o=0xCCBBAA zero-extended, word_last_o=1, fill_cnt_o returns to 0.
- word_ready_i=0, stream 5x32 samples:
  - FIFO fills at 4 words; after the 5th word completes, res_ready_o=0 (HOLD).
  - An extra res_valid_i then -> overflow_o=1.
  - Raise word_ready_i -> 5 words drain in order, res_ready_o back to 1.
- 2000 samples with res_last_i on the final one -> 63 words: 62 full, then one holding 16 samples with word_last_o=1 and bits [254:128]=0.
- reset_i=0 for one cycle after 10 samples of a word and 2 queued words -> word_valid_o=0, fill_cnt_o=0. The next 32 samples form a clean word with no stale data.

Source files
------------

// File: rtl/res_packer.sv
// Purpose : packs 8-bit bfm result samples into 255-bit words and queues them for the result sink.
// Latency : a word-completing sample accepted in cycle N is visible on word_valid_o in cycle N+1.
// Backpr. : word_ready_i stalls the word FIFO; when full, a completed word parks in HOLD and res_ready_o drops.
//
// Ports   : clk_i/reset_i (sync, active-low); res_i/res_valid_i/res_last_i/res_ready_o sample input;
//           word_o/word_valid_o/word_ready_i/word_last_o packed-word output; fill_cnt_o partial-word
//           sample count; overflow_o sticky drop flag.
// Option  : RES_PACKER_PARITY_EN adds word_par_o (stored head-word parity) and par_err_inj_i.

// Generic synchronous FIFO: valid/ready on the read side, full flag on the write side.
// Head data is forced to zero while empty so the output is defined out of reset.
module res_packer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         full,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy;
    // A write while full is only legal when the head leaves in the same cycle.
    assign push    = in_vld & (~full | pop);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

module res_packer #(
    parameter int DATA_W         = 8,
    parameter int WORD_W         = 255,
    parameter int BYTES_PER_WORD = 32,
    parameter int DEPTH          = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] res_i,
    input  logic              res_valid_i,
    input  logic              res_last_i,
    output logic              res_ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              word_last_o,
    output logic [5:0]        fill_cnt_o,
    output logic              overflow_o
`ifdef RES_PACKER_PARITY_EN
    ,
    output logic              word_par_o,
    input  logic              par_err_inj_i
`endif
);
    localparam int PACK_W = BYTES_PER_WORD * DATA_W;
    localparam logic [5:0] LAST_IDX = 6'(BYTES_PER_WORD - 1);
`ifdef RES_PACKER_PARITY_EN
    localparam int FW = WORD_W + 2;
`else
    localparam int FW = WORD_W + 1;
`endif

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              last_q, last_d;
    logic [5:0]        fill_q, fill_d;
    logic              overflow_q;

    logic              accept;
    logic              complete;
    logic [WORD_W-1:0] merged;
    logic              push_vld;
    logic [WORD_W-1:0] push_word;
    logic              push_last;
    logic              fifo_full;
    logic              pop;
    logic              space;
    logic [FW-1:0]     push_dat;
    logic [FW-1:0]     head_dat;

    assign res_ready_o = (state_q == S_FILL);
    assign accept      = res_valid_i & res_ready_o;
    assign complete    = accept & (res_last_i | (fill_q == LAST_IDX));
    assign pop         = word_valid_o & word_ready_i;
    assign space       = ~fifo_full | pop;

    // Sample k lands at bits [8k+7:8k]; the top bit of the final sample falls off the 255-bit word.
    assign merged = acc_q | WORD_W'(PACK_W'(res_i) << (DATA_W * int'(fill_q)));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        last_d    = last_q;
        fill_d    = fill_q;
        push_vld  = 1'b0;
        push_word = merged;
        push_last = res_last_i;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (complete) begin
                        fill_d = '0;
                        if (space) begin
                            push_vld = 1'b1;
                            acc_d    = '0;
                        end else begin
                            // Park the finished word in the accumulator until the FIFO frees a slot.
                            state_d = S_HOLD;
                            acc_d   = merged;
                            last_d  = res_last_i;
                        end
                    end else begin
                        acc_d  = merged;
                        fill_d = fill_q + 6'd1;
                    end
                end
            end
            S_HOLD: begin
                push_word = acc_q;
                push_last = last_q;
                if (space) begin
                    push_vld = 1'b1;
                    acc_d    = '0;
                    last_d   = 1'b0;
                    state_d  = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= S_FILL;
            acc_q      <= '0;
            last_q     <= 1'b0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            fill_q  <= fill_d;
            if (res_valid_i & ~res_ready_o) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef RES_PACKER_PARITY_EN
    assign push_dat = {(^push_word) ^ par_err_inj_i, push_last, push_word};
    assign {word_par_o, word_last_o, word_o} = head_dat;
`else
    assign push_dat = {push_last, push_word};
    assign {word_last_o, word_o} = head_dat;
`endif

    res_packer_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .in_vld  (push_vld),
        .in_dat  (push_dat),
        .full    (fifo_full),
        .out_vld (word_valid_o),
        .out_rdy (word_ready_i),
        .out_dat (head_dat)
    );

    assign fill_cnt_o = fill_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_res_packer.sv
module tb_res_packer;
    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic [7:0]   res_i = 8'h00;
    logic         res_valid_i = 1'b0;
    logic         res_last_i = 1'b0;
    logic         res_ready_o;
    logic [254:0] word_o;
    logic         word_valid_o;
    logic         word_ready_i = 1'b0;
    logic         word_last_o;
    logic [5:0]   fill_cnt_o;
    logic         overflow_o;

    res_packer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .res_i        (res_i),
        .res_valid_i  (res_valid_i),
        .res_last_i   (res_last_i),
        .res_ready_o  (res_ready_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_last_o  (word_last_o),
        .fill_cnt_o   (fill_cnt_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [254:0] w;
        logic         l;
    } exp_t;

    // Reference model: packet bytes so far, words resident in the output buffer,
    // a parked completed word, and the sticky drop flag.
    logic [7:0] bytes[$];
    exp_t       exp_q[$];
    int         occ = 0;
    bit         hold = 0;
    bit         ovf = 0;
    int         checks = 0;
    int         errors = 0;
    int         words_seen = 0;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("res_ready", 256'(res_ready_o), 256'(!hold));
        chk("fill_cnt", 256'(fill_cnt_o), 256'(bytes.size()));
        chk("overflow", 256'(overflow_o), 256'(ovf));
        chk("word_valid", 256'(word_valid_o), 256'(occ > 0));
    endtask

    task automatic complete_word(input bit l);
        logic [255:0] packed_w;
        exp_t e;
        packed_w = '0;
        foreach (bytes[k]) packed_w[8*k +: 8] = bytes[k];
        e.w = packed_w[254:0];
        e.l = l;
        exp_q.push_back(e);
        bytes.delete();
    endtask

    // One clock: drive inputs, advance the model, then compare state after the edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit wr, output bit accepted);
        bit pop;
        bit space;
        bit pushed;
        res_valid_i  = v;
        res_i        = d;
        res_last_i   = l;
        word_ready_i = wr;
        pop      = (occ > 0) && wr;
        space    = (occ < DEPTH) || pop;
        pushed   = 0;
        accepted = v && !hold;
        if (hold) begin
            if (v) ovf = 1;
            if (space) begin
                pushed = 1;
                hold   = 0;
            end
        end else if (v) begin
            bytes.push_back(d);
            if (l || bytes.size() == 32) begin
                complete_word(l);
                if (space) pushed = 1;
                else hold = 1;
            end
        end
        occ = occ - int'(pop) + int'(pushed);
        @(posedge clk_i);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset_i      = 1'b0;
        res_valid_i  = 1'b0;
        res_last_i   = 1'b0;
        word_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        bytes.delete();
        exp_q.delete();
        occ  = 0;
        hold = 0;
        ovf  = 0;
        check_state();
        chk("word_o_reset", 256'(word_o), 256'(0));
        chk("word_last_reset", 256'(word_last_o), 256'(0));
    endtask

    task automatic drain();
        bit a;
        int n = 0;
        while ((occ > 0 || hold) && n < 60) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
            n++;
        end
        chk("drain_done", 256'(occ == 0 && !hold), 256'(1));
    endtask

    // Monitor: every accepted output word is matched against the model's expectation queue.
    always @(negedge clk_i) begin
        if (reset_i && word_valid_o && word_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word got %0h expected none at %0t", word_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word_o", 256'(word_o), 256'(mon_e.w));
                chk("word_last", 256'(word_last_o), 256'(mon_e.l));
                words_seen++;
            end
        end
    end

    initial begin
        bit a;
        int base;
        int n;
        int guard;
        bit v;

        do_reset();

        // Ascending bytes: one full word, no last.
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1, a);
        drain();

        // Final sample 0xFF loses its top bit.
        for (int i = 0; i < 32; i++) cycle(1'b1, (i == 31) ? 8'hFF : 8'h00, 1'b0, 1'b1, a);
        drain();

        // Short packet flushed by last.
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, a);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1, a);
        cycle(1'b1, 8'hCC, 1'b1, 1'b1, a);
        drain();

        // 2000-sample packet with random backpressure and random gaps.
        base  = words_seen;
        n     = 0;
        guard = 0;
        while (n < 2000 && guard < 20000) begin
            v = !hold && ($urandom_range(0, 3) != 0);
            cycle(v, 8'($urandom), v && (n == 1999), $urandom_range(0, 3) != 0, a);
            if (a) n++;
            guard++;
        end
        chk("accepted_2000", 256'(n), 256'(2000));
        drain();
        chk("words_2000", 256'(words_seen - base), 256'(63));

        // Fill the FIFO with the consumer stalled, then hit HOLD and overflow.
        base = words_seen;
        for (int i = 0; i < 160; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, a);
        chk("hold_after_5", 256'(res_ready_o), 256'(0));
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, a);
        chk("overflow_set", 256'(overflow_o), 256'(1));
        drain();
        chk("words_5", 256'(words_seen - base), 256'(5));

        // Free-running random traffic including drops while parked.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, a);
        drain();

        // Reset with two queued words and a partial word, then a clean word.
        for (int i = 0; i < 74; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, a);
        do_reset();
        base = words_seen;
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, a);
        drain();
        chk("words_after_reset", 256'(words_seen - base), 256'(1));

        chk("exp_empty", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
